lc3_mem_ctrl: RTL
=================

// Module: lc3_mem_ctrl
// PURPOSE
//  Memory-side stage downstream of the ISDU control FSM. Converts the ISDU's level
//  Mem_OE/Mem_WE requests into timed async-SRAM cycles, and returns read data to MDR
//  with a Mem_Rdy handshake, so the ISDU can stall instead of using fixed wait states.
//  Decodes one memory-mapped I/O word: reads of it return the switches; writes to it
//  load the hex-display register.
// PARAMETERS
//  WAIT_CYCLES  1         extra SRAM access cycles beyond the minimum (0..15)
//  ADDR_W       20        SRAM address width; MAR is zero-extended into it
//  DATA_W       16        data word width
//  MMIO_ADDR    16'hFFFF  I/O word address (switches on read, hex register on write)
// PORTS
//  Clk            in   1       clock
//  Reset          in   1       synchronous, active-high
//  Mem_OE         in   1       read request (level, held until Mem_Rdy seen)
//  Mem_WE         in   1       write request (level, held until Mem_Rdy seen)
//  MAR            in   16      access address
//  MDR_out        in   DATA_W  write data from MDR
//  Data_to_CPU    out  DATA_W  read data to MDR input mux (registered)
//  Mem_Rdy        out  1       access complete; high while in DONE
//  Switches       in   DATA_W  board switches (MMIO read source)
//  HEX_Data       out  DATA_W  hex-display register (MMIO write target)
//  SRAM_ADDR      out  ADDR_W  {0, MAR}
//  SRAM_CE_N      out  1       chip enable, active-low
//  SRAM_OE_N      out  1       output enable, active-low
//  SRAM_WE_N      out  1       write enable, active-low
//  SRAM_UB_N/LB_N out  1 each  byte lanes; tied 0 whenever CE_N=0, else 1
//  SRAM_DQ_o      out  DATA_W  write data (= MDR_out, registered at WR_SETUP entry)
//  SRAM_DQ_oe     out  1       DQ driver enable; top-level builds the tristate
//  SRAM_DQ_i      in   DATA_W  DQ read value
// BEHAVIOUR
//  - Reset values: state=IDLE, Data_to_CPU=0, HEX_Data=0, Mem_Rdy=0, all *_N=1, DQ_oe=0.
//    A reset mid-access aborts the access at the next edge; no partial write is retried.
//  - Strobes are a Moore decode of the state register only, so they have no
//    combinational path from the inputs.
//  - States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, IO, DONE.
//  - IDLE: requests are sampled at each edge.
//    - Mem_WE=1 -> WR_SETUP, or IO if MAR==MMIO_ADDR. Write has priority if both are high.
//    - Mem_OE=1 -> RD, or IO if MAR==MMIO_ADDR.
//    - Otherwise stay in IDLE.
//  - RD: CE_N=0, OE_N=0 for WAIT_CYCLES+1 cycles (down-counter).
//    - On the last RD edge, Data_to_CPU <= SRAM_DQ_i -> DONE.
//    - Read latency: Mem_Rdy is high WAIT_CYCLES+2 cycles after the first cycle Mem_OE is high.
//  - WR_SETUP: 1 cycle, CE_N=0, WE_N=1, DQ_oe=1.
//  - WR_PULSE: WAIT_CYCLES+1 cycles, WE_N=0, DQ_oe=1.
//  - WR_HOLD: 1 cycle, WE_N=1, DQ_oe=1 -> DONE.
//    - Write latency is WAIT_CYCLES+4. WE_N is never low in the same cycle DQ_oe rises or falls.
//  - IO: 1 cycle, no SRAM strobes -> DONE.
//    - For a read, Data_to_CPU <= Switches.
//    - For a write, HEX_Data <= MDR_out.
//  - DONE: Mem_Rdy=1 and Data_to_CPU held stable.
//    - Stays in DONE while Mem_OE|Mem_WE; goes to IDLE the cycle after both are low.
//    - A new request therefore needs at least 1 low cycle in between.
//  - A request dropped mid-access does not abort: the access completes, DONE lasts 1 cycle,
//    then IDLE.
//  - MAR/MDR_out are captured when leaving IDLE. Changes during the access are ignored.
//  - SRAM_ADDR is held from the captured MAR for the whole access, including WR_HOLD.
// STRUCTURE
//  - Package lc3_mem_pkg: mem_state_t enum, MMIO_ADDR_DEF=16'hFFFF, WAIT_W=4.
//  - Single module: the wait counter, the MMIO decode and the HEX register are inline.
//    No sub-module.
// TESTING
//  - Read, WAIT_CYCLES=1, SRAM model returns 16'h1234 at 0x0003:
//    Mem_OE held -> OE_N low for 2 cycles, Mem_Rdy in cycle 3, Data_to_CPU=16'h1234.
//  - Write MDR=16'hBEEF to 0x0010:
//    WE_N low exactly 2 cycles, DQ_oe spans WE_N low ±1 cycle, model word=16'hBEEF, Rdy in cycle 5.
//  - MMIO: Switches=16'h00A5, read 0xFFFF -> Data_to_CPU=16'h00A5 at cycle 2, no CE_N pulse.
//    Write 16'h0042 -> HEX_Data=16'h0042 and the SRAM is untouched.
//  - Mem_OE and Mem_WE both high -> write cycle is performed, OE_N stays high.
//  - Reset asserted during WR_PULSE -> next cycle all *_N=1, DQ_oe=0, Mem_Rdy=0,
//    HEX_Data=0, state IDLE.
//  - Back-to-back reads held high through DONE -> no second access until the request drops
//    for 1 cycle; Data_to_CPU stable throughout DONE.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_pkg
//  Description : Shared types and constants for the LC-3 memory controller.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3_mem_pkg;

  // Default memory-mapped I/O word: switches on read, hex register on write
  localparam logic [15:0] MMIO_ADDR_DEF = 16'hFFFF;

  // Width of the SRAM wait-state down-counter
  localparam int WAIT_W = 4;

  // Memory access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_IO       = 3'd5,
    ST_DONE     = 3'd6
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_ctrl
//  Description : Turns ISDU level read/write requests into timed async-SRAM
//                cycles, returns read data with a Mem_Rdy handshake, and
//                decodes one MMIO word (switches / hex-display register).
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter int          ADDR_W      = 20,
  parameter int          DATA_W      = 16,
  parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [15:0]       MAR,
  input  logic [DATA_W-1:0] MDR_out,
  output logic [DATA_W-1:0] Data_to_CPU,
  output logic              Mem_Rdy,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] HEX_Data,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] SRAM_DQ_o,
  output logic              SRAM_DQ_oe,
  input  logic [DATA_W-1:0] SRAM_DQ_i
);

  // Reload value for the access-length counter (counts down to zero)
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  mem_state_t        state;
  mem_state_t        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              is_write;
  logic              mar_is_mmio;

  assign mar_is_mmio = (MAR == MMIO_ADDR);

  // Address and write data come from the values latched when IDLE was left
  assign SRAM_ADDR = {{(ADDR_W-16){1'b0}}, addr_lat};
  assign SRAM_DQ_o = wdata_lat;
  assign SRAM_UB_N = SRAM_CE_N;
  assign SRAM_LB_N = SRAM_CE_N;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and Moore decode of strobes from the state register only
  always_comb begin
    state_next = state;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_DQ_oe = 1'b0;
    Mem_Rdy    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Write wins when both requests are present
        if (Mem_WE)      state_next = mar_is_mmio ? ST_IO : ST_WR_SETUP;
        else if (Mem_OE) state_next = mar_is_mmio ? ST_IO : ST_RD;
      end
      ST_RD: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        if (wait_cnt == '0) state_next = ST_DONE;
      end
      ST_WR_SETUP: begin
        SRAM_CE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
        state_next = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_WE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
        if (wait_cnt == '0) state_next = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        SRAM_CE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
        state_next = ST_DONE;
      end
      ST_IO: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        Mem_Rdy = 1'b1;
        // Hold here until the ISDU drops its request
        if (!(Mem_OE || Mem_WE)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counter, read-data and hex-display registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt    <= '0;
      addr_lat    <= '0;
      wdata_lat   <= '0;
      is_write    <= 1'b0;
      Data_to_CPU <= '0;
      HEX_Data    <= '0;
    end else begin
      // Track MAR/MDR while idle so the values on the departing edge stick
      if (state == ST_IDLE) begin
        addr_lat  <= MAR;
        wdata_lat <= MDR_out;
        is_write  <= Mem_WE;
      end
      // Reload before RD and before WR_PULSE; count down inside them
      if (state == ST_IDLE || state == ST_WR_SETUP) wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != '0)                      wait_cnt <= wait_cnt - 1'b1;
      if (state == ST_RD && wait_cnt == '0) Data_to_CPU <= SRAM_DQ_i;
      if (state == ST_IO) begin
        if (is_write) HEX_Data    <= wdata_lat;
        else          Data_to_CPU <= Switches;
      end
    end
  end

endmodule
`default_nettype wire
